// File: rtl/fetch_unit_ms.sv
// fetch_unit_ms: instruction fetch stage with multi-word instruction assembly.
// The stage holds the PC and reads an asynchronous-read instruction memory.
// An opcode word whose top OPC_W bits equal EXT_OPCODE is followed by
// EXT_WORDS immediate words. The stage collects all of these words into one
// registered bundle for decode. Redirects are prioritised. Interrupts are
// deferred to instruction boundaries.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   imem_addr/rdata     memory address (equals PC) and same-cycle read data
//   stall               hold fetch state and outputs
//   exception           redirect to RESET_VEC (highest priority)
//   interrupt, set_int  hardware / software interrupt requests
//   pop_pc, pc_pop      redirect to popped return address
//   jmp, pc_jmp         redirect to jump target
//   instr_o, imm_o      opcode word and immediates (word 0 in the MS slot)
//   pc_o                address following the last word of the bundle
//   valid_o, int_o      bundle valid; first bundle after interrupt entry
module fetch_unit_ms #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned OPC_W      = 4,
  parameter int unsigned EXT_OPCODE = 8,
  parameter int unsigned EXT_WORDS  = 1,
  parameter int unsigned RESET_VEC  = 32,
  parameter int unsigned INT_VEC    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         stall,
  input  logic                         exception,
  input  logic                         interrupt,
  input  logic                         set_int,
  input  logic                         pop_pc,
  input  logic [ADDR_W-1:0]            pc_pop,
  input  logic                         jmp,
  input  logic [ADDR_W-1:0]            pc_jmp,
  output logic [INSTR_W-1:0]           instr_o,
  output logic [EXT_WORDS*INSTR_W-1:0] imm_o,
  output logic [ADDR_W-1:0]            pc_o,
  output logic                         valid_o,
  output logic                         int_o
);

  localparam int unsigned CNT_W = (EXT_WORDS > 1) ? $clog2(EXT_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXT_WORDS - 1);

  typedef enum logic {OP, EXT} state_t;

  state_t                       state, state_n;
  logic [ADDR_W-1:0]            pc, pc_n, pc_inc;
  logic [CNT_W-1:0]             cnt, cnt_n;
  logic                         int_pending, int_pending_n;
  logic                         int_mark, int_mark_n;
  logic [INSTR_W-1:0]           instr_n;
  logic [EXT_WORDS*INSTR_W-1:0] imm_n;
  logic [ADDR_W-1:0]            pc_o_n;
  logic                         valid_n, int_n;

  logic redirect, take_int, is_ext_op, last_word;

  assign imem_addr = pc;
  assign pc_inc    = pc + ADDR_W'(1);
  assign redirect  = exception | pop_pc | jmp;
  // Interrupts are only taken at an instruction boundary, never mid-assembly.
  assign take_int  = int_pending && (state == OP) && !stall;
  assign is_ext_op = (imem_rdata[INSTR_W-1 -: OPC_W] == OPC_W'(EXT_OPCODE));
  assign last_word = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= OP;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    if (redirect || take_int) begin
      state_n = OP;
    end else if (!stall) begin
      if (state == OP) begin
        if (is_ext_op) state_n = EXT;
      end else if (last_word) begin
        state_n = OP;
      end
    end
  end

  // Next values for the PC, the assembly counter and the output bundle
  always_comb begin
    pc_n          = pc;
    cnt_n         = cnt;
    int_pending_n = int_pending | interrupt | set_int;
    int_mark_n    = int_mark;
    instr_n       = instr_o;
    imm_n         = imm_o;
    pc_o_n        = pc_o;
    valid_n       = valid_o;
    int_n         = int_o;
    if (exception) begin
      pc_n          = ADDR_W'(RESET_VEC);
      valid_n       = 1'b0;
      int_n         = 1'b0;
      int_pending_n = 1'b0;
    end else if (pop_pc) begin
      pc_n    = pc_pop;
      valid_n = 1'b0;
      int_n   = 1'b0;
    end else if (jmp) begin
      pc_n    = pc_jmp;
      valid_n = 1'b0;
      int_n   = 1'b0;
    end else if (take_int) begin
      pc_n          = ADDR_W'(INT_VEC);
      valid_n       = 1'b0;
      int_n         = 1'b0;
      // A request arriving on the entry edge stays pending.
      int_pending_n = interrupt | set_int;
      int_mark_n    = 1'b1;
    end else if (!stall) begin
      pc_n    = pc_inc;
      valid_n = 1'b0;
      int_n   = 1'b0;
      if (state == OP) begin
        instr_n = imem_rdata;
        imm_n   = '0;
        if (is_ext_op) begin
          cnt_n = '0;
        end else begin
          pc_o_n     = pc_inc;
          valid_n    = 1'b1;
          int_n      = int_mark;
          int_mark_n = 1'b0;
        end
      end else begin
        // Immediate word cnt lands in slot cnt counted from the MS end.
        for (int unsigned i = 0; i < EXT_WORDS; i++) begin
          if (cnt == CNT_W'(i))
            imm_n[(EXT_WORDS-1-i)*INSTR_W +: INSTR_W] = imem_rdata;
        end
        if (last_word) begin
          pc_o_n     = pc_inc;
          valid_n    = 1'b1;
          int_n      = int_mark;
          int_mark_n = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= ADDR_W'(RESET_VEC);
      cnt         <= '0;
      int_pending <= 1'b0;
      int_mark    <= 1'b0;
      instr_o     <= '0;
      imm_o       <= '0;
      pc_o        <= '0;
      valid_o     <= 1'b0;
      int_o       <= 1'b0;
    end else begin
      pc          <= pc_n;
      cnt         <= cnt_n;
      int_pending <= int_pending_n;
      int_mark    <= int_mark_n;
      instr_o     <= instr_n;
      imm_o       <= imm_n;
      pc_o        <= pc_o_n;
      valid_o     <= valid_n;
      int_o       <= int_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit_ms.sv
module tb_fetch_unit_ms;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall, exception, interrupt, set_int, pop_pc, jmp;
  logic [31:0] pc_pop, pc_jmp;
  logic [15:0] instr_o;
  logic [31:0] imm_o;
  logic [31:0] pc_o;
  logic        valid_o, int_o;

  logic [15:0] mem [0:511];
  assign imem_rdata = mem[imem_addr[8:0]];

  always #5 clk = ~clk;

  fetch_unit_ms #(
    .ADDR_W(32), .INSTR_W(16), .OPC_W(4), .EXT_OPCODE(8),
    .EXT_WORDS(2), .RESET_VEC(32), .INT_VEC(0)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .exception(exception), .interrupt(interrupt),
    .set_int(set_int), .pop_pc(pop_pc), .pc_pop(pc_pop),
    .jmp(jmp), .pc_jmp(pc_jmp),
    .instr_o(instr_o), .imm_o(imm_o), .pc_o(pc_o),
    .valid_o(valid_o), .int_o(int_o)
  );

  typedef struct {
    logic [15:0] instr;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        intr;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic last_stall = 1'b1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  function automatic void expect_bundle(logic [15:0] i, logic [31:0] m, logic [31:0] p, logic n);
    exp_t e;
    e.instr = i; e.imm = m; e.pc = p; e.intr = n;
    q.push_back(e);
  endfunction

  // Stall value seen by the edge that produced the current outputs.
  always @(posedge clk) last_stall <= stall;

  // Monitor: each freshly produced bundle is popped and compared.
  always @(negedge clk) begin
    if (!reset && valid_o && !last_stall) begin
      if (q.size() == 0) begin
        chk("unexpected_bundle_pc", {32'h0, pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bundle_instr", {48'h0, instr_o}, {48'h0, e.instr});
        chk("bundle_imm",   {32'h0, imm_o},   {32'h0, e.imm});
        chk("bundle_pc",    {32'h0, pc_o},    {32'h0, e.pc});
        chk("bundle_int",   {63'h0, int_o},   {63'h0, e.intr});
      end
    end
  end

  task automatic step(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 16'h0;
    reset = 1'b1; stall = 1'b1; exception = 1'b0; interrupt = 1'b0;
    set_int = 1'b0; pop_pc = 1'b0; jmp = 1'b0; pc_pop = '0; pc_jmp = '0;
    #2;
    chk("reset_valid", {63'h0, valid_o}, 64'h0);
    chk("reset_int",   {63'h0, int_o},   64'h0);
    chk("reset_instr", {48'h0, instr_o}, 64'h0);
    chk("reset_imm",   {32'h0, imm_o},   64'h0);
    chk("reset_pc_o",  {32'h0, pc_o},    64'h0);
    step(1);
    reset = 1'b0;
    chk("reset_addr", {32'h0, imem_addr}, 64'd32);

    // 1: two single-word instructions
    mem[32] = 16'h1234; mem[33] = 16'h2000;
    expect_bundle(16'h1234, 32'h0, 32'd33, 1'b0);
    expect_bundle(16'h2000, 32'h0, 32'd34, 1'b0);
    stall = 1'b0;
    step(2);
    stall = 1'b1;
    chk("s1_addr", {32'h0, imem_addr}, 64'd34);

    // 2: three-word instruction
    exception = 1'b1; step(1); exception = 1'b0;
    chk("s2_addr_redirect", {32'h0, imem_addr}, 64'd32);
    mem[32] = 16'h8005; mem[33] = 16'hAAAA; mem[34] = 16'hBBBB;
    expect_bundle(16'h8005, 32'hAAAABBBB, 32'd35, 1'b0);
    stall = 1'b0;
    step(1); chk("s2_valid_c1", {63'h0, valid_o}, 64'h0);
    step(1); chk("s2_valid_c2", {63'h0, valid_o}, 64'h0);
    step(1);
    stall = 1'b1;
    chk("s2_addr_end", {32'h0, imem_addr}, 64'd35);

    // 3: stall while collecting immediates
    exception = 1'b1; step(1); exception = 1'b0;
    expect_bundle(16'h8005, 32'hAAAABBBB, 32'd35, 1'b0);
    stall = 1'b0; step(1); stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("s3_stall_addr",  {32'h0, imem_addr}, 64'd33);
      chk("s3_stall_valid", {63'h0, valid_o},   64'h0);
    end
    stall = 1'b0; step(2); stall = 1'b1;

    // 4: interrupt during immediate collection is deferred
    exception = 1'b1; step(1); exception = 1'b0;
    mem[0] = 16'h1111; mem[1] = 16'h2222;
    expect_bundle(16'h8005, 32'hAAAABBBB, 32'd35, 1'b0);
    expect_bundle(16'h1111, 32'h0, 32'd1, 1'b1);
    expect_bundle(16'h2222, 32'h0, 32'd2, 1'b0);
    stall = 1'b0;
    step(1);
    interrupt = 1'b1; step(1); interrupt = 1'b0;
    step(1);
    step(1);
    chk("s4_int_addr",  {32'h0, imem_addr}, 64'd0);
    chk("s4_int_valid", {63'h0, valid_o},   64'h0);
    step(2);
    stall = 1'b1;

    // 5: redirect priorities
    jmp = 1'b1; pc_jmp = 32'h100; exception = 1'b1;
    step(1);
    exception = 1'b0;
    chk("s5_exc_over_jmp", {32'h0, imem_addr}, 64'd32);
    step(1);
    chk("s5_jmp_stalled", {32'h0, imem_addr}, 64'h100);
    chk("s5_jmp_valid",   {63'h0, valid_o},   64'h0);
    pop_pc = 1'b1; pc_pop = 32'h200;
    step(1);
    pop_pc = 1'b0; jmp = 1'b0;
    chk("s5_pop_over_jmp", {32'h0, imem_addr}, 64'h200);

    // 6: PC wrap, then async reset in the middle of assembly
    mem[511] = 16'h3333;
    jmp = 1'b1; pc_jmp = 32'hFFFF_FFFF; step(1); jmp = 1'b0;
    expect_bundle(16'h3333, 32'h0, 32'h0, 1'b0);
    stall = 1'b0; step(1); stall = 1'b1;
    chk("s6_wrap_addr", {32'h0, imem_addr}, 64'h0);
    exception = 1'b1; step(1); exception = 1'b0;
    stall = 1'b0; step(1); stall = 1'b1;
    chk("s6_mid_instr", {48'h0, instr_o}, 64'h8005);
    #2 reset = 1'b1;
    #1;
    chk("s6_rst_instr", {48'h0, instr_o}, 64'h0);
    chk("s6_rst_valid", {63'h0, valid_o}, 64'h0);
    chk("s6_rst_pc_o",  {32'h0, pc_o},    64'h0);
    chk("s6_rst_addr",  {32'h0, imem_addr}, 64'd32);
    step(1);
    reset = 1'b0;
    expect_bundle(16'h8005, 32'hAAAABBBB, 32'd35, 1'b0);
    stall = 1'b0; step(3); stall = 1'b1;
    step(2);
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
